multi_issue_queue: RTL and testbench



---
 rtl/multi_issue_queue.sv | 109 ++++++++++
 tb/tb_multi_issue_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_issue_queue.sv
// rtl/multi_issue_queue.sv - circular instruction buffer with in-order hazard-checked multi-issue
module multi_issue_queue #(
    parameter int ISSUE_WIDTH     = 2,
    parameter int DEPTH           = 8,
    parameter int CTRL_ENDS_GROUP = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ISSUE_WIDTH-1:0]      in_valid,
    input  logic [32*ISSUE_WIDTH-1:0]   in_instr,
    output logic                        in_ready,
    input  logic                        stall,
    input  logic                        flush,
    output logic [ISSUE_WIDTH-1:0]      issue_valid,
    output logic [32*ISSUE_WIDTH-1:0]   issue_instr,
    output logic [ISSUE_WIDTH-1:0]      freeze,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    logic [31:0]            mem [DEPTH];
    logic [AW-1:0]          head;
    logic [AW-1:0]          tail;
    logic [CW-1:0]          count_q;
    logic [31:0]            slot [ISSUE_WIDTH];
    logic [ISSUE_WIDTH-1:0] wr, use1, use2, ctl, hz;
    logic [CW-1:0]          push_n;
    logic [CW-1:0]          pop_n;

    assign count    = count_q;
    assign in_ready = (int'(count_q) + ISSUE_WIDTH) <= DEPTH;

    always_comb begin
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            slot[k] = mem[head + AW'(k)];
            wr[k]   = (slot[k][6:0] != OP_STORE) && (slot[k][6:0] != OP_BRANCH) && (slot[k][11:7] != 5'd0);
            use1[k] = !((slot[k][6:0] == OP_LUI) || (slot[k][6:0] == OP_AUIPC) || (slot[k][6:0] == OP_JAL));
            use2[k] = (slot[k][6:0] == OP_OP) || (slot[k][6:0] == OP_STORE) || (slot[k][6:0] == OP_BRANCH);
            ctl[k]  = (slot[k][6:0] == OP_BRANCH) || (slot[k][6:0] == OP_JAL) || (slot[k][6:0] == OP_JALR);
        end
    end

    // Pairwise check of each slot against every older slot in the candidate group.
    always_comb begin
        hz = '0;
        for (int k = 1; k < ISSUE_WIDTH; k++) begin
            for (int j = 0; j < k; j++) begin
                if (wr[j] && ((use1[k] && slot[j][11:7] == slot[k][19:15]) ||
                              (use2[k] && slot[j][11:7] == slot[k][24:20]) ||
                              (wr[k]   && slot[j][11:7] == slot[k][11:7])))
                    hz[k] = 1'b1;
                if ((CTRL_ENDS_GROUP != 0) && ctl[j])
                    hz[k] = 1'b1;
            end
        end
    end

    always_comb begin
        issue_valid    = '0;
        issue_instr    = '0;
        freeze         = '0;
        pop_n          = '0;
        push_n         = '0;
        issue_valid[0] = (count_q != '0) && !stall;
        for (int k = 1; k < ISSUE_WIDTH; k++)
            issue_valid[k] = issue_valid[k-1] && (int'(count_q) > k) && !hz[k];
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            issue_instr[32*k +: 32] = issue_valid[k] ? slot[k] : 32'd0;
            freeze[k]               = (int'(count_q) > k) && !issue_valid[k];
            pop_n                   = pop_n + CW'(issue_valid[k]);
            push_n                  = push_n + CW'(in_valid[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= tail;
            count_q <= '0;
        end else begin
            if (in_ready)
                tail <= tail + AW'(push_n);
            head    <= head + AW'(pop_n);
            count_q <= count_q + (in_ready ? push_n : CW'(0)) - pop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && in_ready) begin
            for (int i = 0; i < ISSUE_WIDTH; i++)
                if (in_valid[i])
                    mem[tail + AW'(i)] <= in_instr[32*i +: 32];
        end
    end

endmodule

// File: tb/tb_multi_issue_queue.sv
// tb/tb_multi_issue_queue.sv - directed bench with a queue-level reference model
module tb_multi_issue_queue;

    localparam int W     = 2;
    localparam int DEPTH = 8;
    localparam int CEG   = 1;

    logic          clk, rst, stall, flush, in_ready;
    logic [W-1:0]  in_valid, issue_valid, freeze;
    logic [63:0]   in_instr, issue_instr;
    logic [3:0]    count;

    int total = 0;
    int bad   = 0;

    multi_issue_queue #(.ISSUE_WIDTH(W), .DEPTH(DEPTH), .CTRL_ENDS_GROUP(CEG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .stall(stall), .flush(flush), .issue_valid(issue_valid), .issue_instr(issue_instr),
        .freeze(freeze), .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rd, input logic [4:0] rs1);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction

    function automatic void dec(input logic [31:0] ins, output logic w, output logic a1, output logic a2, output logic c);
        logic [6:0] op;
        op = ins[6:0];
        w  = !(op inside {7'b0100011, 7'b1100011}) && (ins[11:7] != 5'd0);
        a1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        a2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        c  = op inside {7'b1100011, 7'b1101111, 7'b1100111};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the queue is a list of instructions; a group is grown
    // from the head while it stays clear of the registers written so far.
    logic [31:0] q[$];
    logic        armed = 1'b0;
    int          m_n;
    logic [31:0] m_wset;
    logic        m_cseen, m_go, m_w, m_a1, m_a2, m_c;
    logic [31:0] m_ins;
    logic [W-1:0] m_ev, m_ef;
    logic [63:0] m_ei;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            m_n = q.size(); m_wset = '0; m_cseen = 1'b0; m_go = 1'b1;
            m_ev = '0; m_ef = '0; m_ei = '0;
            for (int k = 0; k < W; k++) begin
                if (m_go && k < m_n && !(k == 0 && stall)) begin
                    m_ins = q[k];
                    dec(m_ins, m_w, m_a1, m_a2, m_c);
                    if (k > 0 && ((m_a1 && m_wset[m_ins[19:15]]) || (m_a2 && m_wset[m_ins[24:20]]) ||
                                  (m_w && m_wset[m_ins[11:7]]) || (CEG != 0 && m_cseen)))
                        m_go = 1'b0;
                    else begin
                        m_ev[k] = 1'b1;
                        m_ei[32*k +: 32] = m_ins;
                        if (m_w) m_wset[m_ins[11:7]] = 1'b1;
                        if (m_c) m_cseen = 1'b1;
                    end
                end else
                    m_go = 1'b0;
                m_ef[k] = (k < m_n) && !m_ev[k];
            end
            chk("model_issue_valid", issue_valid, m_ev);
            chk("model_issue_instr", issue_instr, m_ei);
            chk("model_freeze", freeze, m_ef);
            chk("model_count", count, m_n);
            chk("model_in_ready", in_ready, (DEPTH - m_n) >= W);
            if (flush)
                q.delete();
            else begin
                for (int k = 0; k < W; k++)
                    if (m_ev[k]) void'(q.pop_front());
                if ((DEPTH - m_n) >= W)
                    for (int i = 0; i < W; i++)
                        if (in_valid[i]) q.push_back(in_instr[32*i +: 32]);
            end
        end
    end

    task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b, input logic s, input logic f);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = v; in_instr = {b, a}; stall = s; flush = f;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] fi(input int idx);
        return i_op(12'(idx), 5'(8 + (idx % 20)), 5'd0);
    endfunction

    int seq = 0;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = '0; in_instr = '0;
        @(negedge clk);

        repeat (5) begin
            idle();
            chk("reset_issue_valid", issue_valid, 2'b00);
            chk("reset_freeze", freeze, 2'b00);
            chk("reset_count", count, 4'd0);
            chk("reset_in_ready", in_ready, 1'b1);
        end

        drive(2'b11, r_op(7'd0, 5'd3, 5'd1, 5'd2), r_op(7'd0, 5'd5, 5'd3, 5'd4), 1'b0, 1'b0);
        idle();
        chk("raw_valid0", issue_valid, 2'b01);
        chk("raw_freeze0", freeze, 2'b10);
        chk("raw_count0", count, 4'd2);
        chk("raw_instr0", issue_instr, {32'd0, r_op(7'd0, 5'd3, 5'd1, 5'd2)});
        idle();
        chk("raw_valid1", issue_valid, 2'b01);
        chk("raw_instr1", issue_instr, {32'd0, r_op(7'd0, 5'd5, 5'd3, 5'd4)});
        chk("raw_count1", count, 4'd1);
        idle();
        chk("raw_count2", count, 4'd0);

        drive(2'b11, r_op(7'd0, 5'd3, 5'd1, 5'd2), r_op(7'h20, 5'd6, 5'd4, 5'd5), 1'b0, 1'b0);
        idle();
        chk("indep_valid", issue_valid, 2'b11);
        chk("indep_instr", issue_instr, {r_op(7'h20, 5'd6, 5'd4, 5'd5), r_op(7'd0, 5'd3, 5'd1, 5'd2)});
        chk("indep_count", count, 4'd2);
        idle();
        chk("indep_count_after", count, 4'd0);

        drive(2'b11, i_op(12'd1, 5'd0, 5'd1), r_op(7'd0, 5'd2, 5'd0, 5'd0), 1'b0, 1'b0);
        idle();
        chk("x0_valid", issue_valid, 2'b11);
        idle();

        drive(2'b11, i_op(12'd1, 5'd7, 5'd1), i_op(12'd2, 5'd7, 5'd2), 1'b0, 1'b0);
        idle();
        chk("waw_valid0", issue_valid, 2'b01);
        chk("waw_freeze0", freeze, 2'b10);
        idle();
        chk("waw_valid1", issue_valid, 2'b01);
        idle();

        drive(2'b11, beq(5'd1, 5'd2), r_op(7'd0, 5'd9, 5'd10, 5'd11), 1'b0, 1'b0);
        idle();
        chk("ctrl_valid", issue_valid, 2'b01);
        idle();
        idle();

        for (int i = 0; i < 4; i++) begin
            drive(2'b11, fi(seq), fi(seq + 1), 1'b0, 1'b0);
            seq += 2;
            if (i > 0) chk("stream_count", count, 4'd2);
        end
        idle();
        idle();

        for (int p = 0; p < 3; p++) begin
            drive(2'b11, fi(seq), fi(seq + 1), 1'b1, 1'b0);
            seq += 2;
        end
        drive(2'b01, fi(seq), 32'd0, 1'b1, 1'b0);
        seq += 1;
        chk("fill_count6", count, 4'd6);
        chk("fill_ready6", in_ready, 1'b1);
        drive(2'b11, fi(seq), fi(seq + 1), 1'b1, 1'b0);
        chk("fill_count7", count, 4'd7);
        chk("fill_ready7", in_ready, 1'b0);
        drive(2'b00, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("stall_hold_count", count, 4'd7);
        chk("stall_freeze", freeze, 2'b11);
        chk("stall_valid", issue_valid, 2'b00);
        for (int c = 7; c > 0; c -= 2) begin
            idle();
            chk("drain_count", count, 4'(c));
            chk("drain_valid", issue_valid, (c >= 2) ? 2'b11 : 2'b01);
        end
        idle();
        chk("drain_empty", count, 4'd0);

        drive(2'b11, fi(seq), fi(seq + 1), 1'b1, 1'b0);
        drive(2'b11, fi(seq + 2), fi(seq + 3), 1'b1, 1'b0);
        drive(2'b01, fi(seq + 4), 32'd0, 1'b1, 1'b0);
        seq += 5;
        drive(2'b11, fi(seq), fi(seq + 1), 1'b0, 1'b1);
        chk("flush_pre_count", count, 4'd5);
        chk("flush_pre_valid", issue_valid, 2'b11);
        idle();
        chk("flush_count", count, 4'd0);
        chk("flush_valid", issue_valid, 2'b00);
        chk("flush_freeze", freeze, 2'b00);
        drive(2'b11, r_op(7'd0, 5'd3, 5'd1, 5'd2), r_op(7'h20, 5'd6, 5'd4, 5'd5), 1'b0, 1'b0);
        idle();
        chk("post_flush_valid", issue_valid, 2'b11);
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
